// File: rtl/uart_peripheral_pkg.sv
// Shared definitions for the memory-mapped 8N1 UART peripheral: register map,
// CON bit layout and the TX/RX state encodings.
package uart_peripheral_pkg;

  localparam logic [31:0] UART_BASE_ADDR = 32'h4000_0018;

  localparam logic [1:0] REG_TXD = 2'd0;
  localparam logic [1:0] REG_RXD = 2'd1;
  localparam logic [1:0] REG_CON = 2'd2;
  localparam logic [1:0] REG_RSV = 2'd3;

  localparam int CON_RX_VALID  = 0;
  localparam int CON_TX_BUSY   = 1;
  localparam int CON_OVERRUN   = 2;
  localparam int CON_FRAME_ERR = 3;
  localparam int CON_RX_IRQ_EN = 4;
  localparam int CON_TX_IRQ_EN = 5;
  localparam int CON_TX_DONE   = 6;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Field order matches the CON bit positions, MSB first.
  typedef struct packed {
    logic tx_done;
    logic tx_irq_en;
    logic rx_irq_en;
    logic frame_err;
    logic overrun;
    logic tx_busy;
    logic rx_valid;
  } con_t;

  function automatic logic [31:0] con_word(con_t c);
    return {25'b0, c};
  endfunction

endpackage

// File: rtl/uart_peripheral_if.sv
// CPU-side register bus of the UART: decoded strobes in, read data and IRQ out.
interface uart_peripheral_if;
  logic [1:0]  Address;
  logic [31:0] Write_data;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Read_data;
  logic        IRQ;

  modport master (output Address, Write_data, MemWrite, MemRead,
                  input  Read_data, IRQ);
  modport slave  (input  Address, Write_data, MemWrite, MemRead,
                  output Read_data, IRQ);
endinterface

// File: rtl/uart_peripheral_rx_core.sv
// 8N1 receiver: 2-FF synchronizer, start-bit validation and mid-bit sampling.
// Emits a one-cycle byte_valid_o or frame_error_o after each stop sample.
//   state    | meaning
//   RX_IDLE  | waiting for a falling edge on the synchronized line
//   RX_START | half-bit wait, then confirm the start bit is still low
//   RX_DATA  | sampling 8 data bits LSB first, one per bit period
//   RX_STOP  | sampling the stop bit, then back to RX_IDLE
module uart_rx_core
  import uart_peripheral_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 10417
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       frame_error_o
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);

  rx_state_e     state_q;
  logic [1:0]    sync_q;
  logic          prev_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          byte_valid_q;
  logic [7:0]    byte_q;
  logic          frame_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RX_IDLE;
      sync_q       <= 2'b11;
      prev_q       <= 1'b1;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], rx_i};
      prev_q       <= sync_q[1];
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (prev_q && !sync_q[1]) begin
            state_q <= RX_START;
            cnt_q   <= HALF_M1;
          end
        end
        RX_START: begin
          if (cnt_q == '0) begin
            // A line already back high at mid-start was a glitch.
            if (sync_q[1]) begin
              state_q <= RX_IDLE;
            end else begin
              state_q <= RX_DATA;
              cnt_q   <= FULL_M1;
              bit_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == '0) begin
            shift_q <= {sync_q[1], shift_q[7:1]};
            cnt_q   <= FULL_M1;
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt_q == '0) begin
            state_q <= RX_IDLE;
            if (sync_q[1]) begin
              byte_valid_q <= 1'b1;
              byte_q       <= shift_q;
            end else begin
              frame_err_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_valid_o  = byte_valid_q;
  assign byte_o        = byte_q;
  assign frame_error_o = frame_err_q;

endmodule

// File: rtl/uart_peripheral.sv
// UART peripheral top: transmitter FSM, TXD/RXD/CON registers, flags and IRQ.
//   state    | meaning
//   TX_IDLE  | line high, accepts a TXD write
//   TX_START | driving the start bit (0)
//   TX_DATA  | shifting out 8 data bits LSB first
//   TX_STOP  | driving the stop bit (1); tx_done set on exit
module uart_peripheral
  import uart_peripheral_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 10417
) (
  input  logic              clk,
  input  logic              reset,
  uart_peripheral_if.slave  bus,
  input  logic              uart_rx,
  output logic              uart_tx
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);

  logic wr_txd, wr_con, rd_rxd;
  assign wr_txd = bus.MemWrite && (bus.Address == REG_TXD);
  assign wr_con = bus.MemWrite && (bus.Address == REG_CON);
  assign rd_rxd = bus.MemRead  && (bus.Address == REG_RXD);

  logic unused_wdata;
  assign unused_wdata = ^bus.Write_data[31:8];

  tx_state_e     tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic          tx_q;
  logic          tx_done_q;
  logic          tx_busy;

  assign tx_busy = (tx_state_q != TX_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      if (wr_con && bus.Write_data[CON_TX_DONE]) tx_done_q <= 1'b0;
      case (tx_state_q)
        TX_IDLE: begin
          if (wr_txd) begin
            tx_state_q <= TX_START;
            tx_shift_q <= bus.Write_data[7:0];
            tx_cnt_q   <= FULL_M1;
            tx_q       <= 1'b0;
            tx_done_q  <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_cnt_q == '0) begin
            tx_state_q <= TX_DATA;
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_bit_q   <= '0;
            tx_cnt_q   <= FULL_M1;
          end else begin
            tx_cnt_q <= tx_cnt_q - CW'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == '0) begin
            tx_cnt_q <= FULL_M1;
            tx_bit_q <= tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= TX_STOP;
              tx_q       <= 1'b1;
            end else begin
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - CW'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == '0) begin
            tx_state_q <= TX_IDLE;
            tx_done_q  <= 1'b1;
          end else begin
            tx_cnt_q <= tx_cnt_q - CW'(1);
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign uart_tx = tx_q;

  logic       rx_byte_valid, rx_frame_error;
  logic [7:0] rx_byte;

  uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx_core (
    .clk           (clk),
    .reset         (reset),
    .rx_i          (uart_rx),
    .byte_valid_o  (rx_byte_valid),
    .byte_o        (rx_byte),
    .frame_error_o (rx_frame_error)
  );

  logic       rx_valid_q,  rx_valid_d;
  logic [7:0] rx_data_q,   rx_data_d;
  logic       overrun_q,   overrun_d;
  logic       frame_err_q, frame_err_d;
  logic       rx_irq_en_q, rx_irq_en_d;
  logic       tx_irq_en_q, tx_irq_en_d;

  always_comb begin
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    rx_irq_en_d = rx_irq_en_q;
    tx_irq_en_d = tx_irq_en_q;
    if (wr_con) begin
      rx_irq_en_d = bus.Write_data[CON_RX_IRQ_EN];
      tx_irq_en_d = bus.Write_data[CON_TX_IRQ_EN];
      if (bus.Write_data[CON_OVERRUN])   overrun_d   = 1'b0;
      if (bus.Write_data[CON_FRAME_ERR]) frame_err_d = 1'b0;
    end
    if (rd_rxd) rx_valid_d = 1'b0;
    // A byte landing on the same edge as an RXD read replaces the one being read.
    if (rx_byte_valid) begin
      rx_valid_d = 1'b1;
      rx_data_d  = rx_byte;
      if (rx_valid_q && !rd_rxd) overrun_d = 1'b1;
    end
    if (rx_frame_error) frame_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      rx_irq_en_q <= 1'b0;
      tx_irq_en_q <= 1'b0;
    end else begin
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      rx_irq_en_q <= rx_irq_en_d;
      tx_irq_en_q <= tx_irq_en_d;
    end
  end

  con_t        con;
  logic [31:0] rdata;

  assign con = {tx_done_q, tx_irq_en_q, rx_irq_en_q, frame_err_q,
                overrun_q, tx_busy, rx_valid_q};

  always_comb begin
    rdata = '0;
    if (bus.MemRead) begin
      case (bus.Address)
        REG_RXD: rdata = {24'b0, rx_data_q};
        REG_CON: rdata = con_word(con);
        default: rdata = '0;
      endcase
    end
  end

  assign bus.Read_data = rdata;
  assign bus.IRQ = (rx_irq_en_q & rx_valid_q) | (tx_irq_en_q & tx_done_q);

endmodule

// File: tb/tb_uart_peripheral.sv
// Scoreboard bench for uart_peripheral: directed scenarios plus random traffic,
// checked against a transaction-level model of the register/flag rules.
module tb_uart_peripheral;
  import uart_peripheral_pkg::*;

  localparam int B = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_rx = 1'b1;
  logic uart_tx;

  uart_peripheral_if bus();

  uart_peripheral #(.BAUD_DIV(B)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: flags as the register map describes them.
  logic       m_rxv, m_ovr, m_ferr, m_rxen, m_txen, m_txdone, m_busy;
  logic [7:0] m_rxdata;
  int         m_tx_end;

  logic [31:0] exp_rd_q[$];
  logic [7:0]  exp_tx_q[$];
  int          exp_tx_cyc_q[$];
  logic        rd_chk = 1'b0;
  logic        mon_tx_en = 1'b1;
  int          lat = 0;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_rxv = 0; m_ovr = 0; m_ferr = 0; m_rxen = 0; m_txen = 0;
    m_txdone = 0; m_busy = 0; m_rxdata = 8'h00; m_tx_end = 0;
    exp_tx_q.delete();
    exp_tx_cyc_q.delete();
  endtask

  // A frame takes 10 bit periods; done becomes visible once that time has passed.
  task automatic settle();
    if (m_busy && cyc >= m_tx_end) begin
      m_busy = 0;
      m_txdone = 1;
    end
  endtask

  function automatic logic [31:0] m_con();
    logic [31:0] w;
    w = '0;
    w[CON_RX_VALID]  = m_rxv;
    w[CON_TX_BUSY]   = m_busy;
    w[CON_OVERRUN]   = m_ovr;
    w[CON_FRAME_ERR] = m_ferr;
    w[CON_RX_IRQ_EN] = m_rxen;
    w[CON_TX_IRQ_EN] = m_txen;
    w[CON_TX_DONE]   = m_txdone;
    return w;
  endfunction

  function automatic logic [31:0] model_read(logic [1:0] a);
    if (a == REG_RXD) return {24'b0, m_rxdata};
    if (a == REG_CON) return m_con();
    return 32'h0;
  endfunction

  task automatic model_write(logic [1:0] a, logic [31:0] d);
    if (a == REG_TXD && !m_busy) begin
      m_busy = 1;
      m_txdone = 0;
      m_tx_end = cyc + 1 + 10 * B;
      if (mon_tx_en) begin
        exp_tx_q.push_back(d[7:0]);
        exp_tx_cyc_q.push_back(cyc + 1);
      end
    end else if (a == REG_CON) begin
      m_rxen = d[4];
      m_txen = d[5];
      if (d[2]) m_ovr = 0;
      if (d[3]) m_ferr = 0;
      if (d[6]) m_txdone = 0;
    end
  endtask

  task automatic bus_cycle(logic rd, logic wr, logic [1:0] a, logic [31:0] d);
    @(posedge clk); #1;
    settle();
    if (rd) exp_rd_q.push_back(model_read(a));
    bus.Address = a; bus.Write_data = d; bus.MemRead = rd; bus.MemWrite = wr;
    rd_chk = rd;
    if (wr) model_write(a, d);
    if (rd && a == REG_RXD) m_rxv = 0;
    @(posedge clk); #1;
    bus.MemRead = 0; bus.MemWrite = 0; rd_chk = 0;
  endtask

  task automatic bus_write(logic [1:0] a, logic [31:0] d); bus_cycle(1'b0, 1'b1, a, d); endtask
  task automatic bus_read(logic [1:0] a);                  bus_cycle(1'b1, 1'b0, a, 32'h0); endtask

  task automatic chk_irq(string name);
    settle();
    check(name, {31'b0, bus.IRQ}, {31'b0, (m_rxen & m_rxv) | (m_txen & m_txdone)});
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one serial frame; optionally measures completion latency via IRQ, or
  // places a single RXD read on the edge where the byte completes.
  task automatic send_rx(logic [7:0] b, logic stop, logic calib, logic same_rd);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int c = 0; c < 10 * B; c++) begin
      @(posedge clk); #1;
      uart_rx = fr[c / B];
      if (same_rd && c == lat - 1) begin
        settle();
        exp_rd_q.push_back({24'b0, m_rxdata});
        bus.Address = REG_RXD; bus.MemRead = 1; rd_chk = 1;
      end else if (same_rd && c == lat) begin
        bus.MemRead = 0; rd_chk = 0;
      end
      if (calib) begin
        @(negedge clk);
        if (bus.IRQ && lat == 0) lat = c;
      end
    end
    @(posedge clk); #1;
    uart_rx = 1'b1;
    bus.MemRead = 0; rd_chk = 0;
    if (stop) begin
      if (m_rxv && !same_rd) m_ovr = 1;
      m_rxv = 1;
      m_rxdata = b;
    end else begin
      m_ferr = 1;
    end
    idle(3);
  endtask

  task automatic glitch();
    @(posedge clk); #1;
    uart_rx = 1'b0;
    idle(4);
    uart_rx = 1'b1;
    idle(30);
  endtask

  // Read-data monitor.
  initial forever begin
    @(negedge clk);
    if (bus.MemRead && rd_chk) begin
      if (exp_rd_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL read_unexpected: got 0x%08h, required no read", bus.Read_data);
      end else begin
        check("read_data", bus.Read_data, exp_rd_q.pop_front());
      end
    end
  end

  // Serial TX monitor: every cycle of every bit must carry the right level.
  logic [7:0] mon_b;
  int         mon_c, mon_start, mon_bad;
  logic       mon_ok, mon_have;
  logic [9:0] mon_fr;
  initial forever begin
    @(negedge clk);
    if (mon_tx_en && uart_tx === 1'b0) begin
      mon_start = cyc;
      mon_have = (exp_tx_q.size() != 0);
      if (mon_have) begin
        mon_b = exp_tx_q.pop_front();
        mon_c = exp_tx_cyc_q.pop_front();
      end else begin
        mon_b = 8'h00;
        mon_c = -1;
      end
      mon_fr = {1'b1, mon_b, 1'b0};
      mon_ok = 1'b1;
      mon_bad = -1;
      for (int k = 0; k < 10 * B; k++) begin
        if (k > 0) @(negedge clk);
        if (uart_tx !== mon_fr[k / B] && mon_ok) begin
          mon_ok = 1'b0;
          mon_bad = k;
        end
      end
      n_cmp++;
      if (!mon_have) begin
        n_err++;
        $display("FAIL tx_extra_frame: got a frame starting cycle %0d, required none", mon_start);
      end else if (!mon_ok || mon_start != mon_c) begin
        n_err++;
        $display("FAIL tx_frame: byte 0x%02h got start cycle %0d / first bad cycle offset %0d, required start cycle %0d / none",
                 mon_b, mon_start, mon_bad, mon_c);
      end
    end
  end

  initial begin
    bus.Address = 2'd0; bus.Write_data = 32'h0; bus.MemRead = 0; bus.MemWrite = 0;
    model_reset();
    idle(3);
    reset = 0;
    check("rst_uart_tx", {31'b0, uart_tx}, 32'h1);
    check("rst_irq", {31'b0, bus.IRQ}, 32'h0);
    check("rst_read_data", bus.Read_data, 32'h0);
    bus_read(REG_CON);

    // Reset in the middle of a TX frame, with an IRQ pending beforehand.
    bus_write(REG_CON, 32'h30);
    send_rx(8'h5A, 1'b1, 1'b0, 1'b0);
    chk_irq("irq_before_reset");
    mon_tx_en = 0;
    bus_write(REG_TXD, 32'hFF);
    idle(40);
    reset = 1;
    #1;
    check("midreset_uart_tx", {31'b0, uart_tx}, 32'h1);
    check("midreset_irq", {31'b0, bus.IRQ}, 32'h0);
    bus.Address = REG_CON; bus.MemRead = 1;
    #1;
    check("midreset_con", bus.Read_data, 32'h0);
    bus.MemRead = 0;
    idle(3);
    reset = 0;
    model_reset();
    mon_tx_en = 1;
    bus_read(REG_CON);
    idle(200);

    // TX 0xA5, ignored second write, done flag.
    bus_write(REG_TXD, 32'hA5);
    bus_read(REG_CON);
    bus_write(REG_TXD, 32'h11);
    idle(170);
    bus_read(REG_CON);

    // RX with interrupt; latency to completion measured here.
    bus_write(REG_CON, 32'h50);
    lat = 0;
    send_rx(8'h3C, 1'b1, 1'b1, 1'b0);
    check("rx_completion_seen", {31'b0, lat > 0}, 32'h1);
    chk_irq("irq_rx_valid");
    bus_read(REG_CON);
    bus_read(REG_RXD);
    bus_read(REG_CON);
    chk_irq("irq_after_rxd_read");

    // Overrun, W1C, and a read on the completion edge.
    bus_write(REG_CON, 32'h00);
    send_rx(8'h12, 1'b1, 1'b0, 1'b0);
    send_rx(8'h34, 1'b1, 1'b0, 1'b0);
    bus_read(REG_CON);
    bus_write(REG_CON, 32'h04);
    bus_read(REG_CON);
    send_rx(8'h56, 1'b1, 1'b0, 1'b1);
    bus_read(REG_CON);
    bus_read(REG_RXD);

    // Frame error, then a short glitch.
    send_rx(8'h99, 1'b0, 1'b0, 1'b0);
    bus_read(REG_CON);
    glitch();
    bus_read(REG_CON);

    // TX done interrupt and its W1C.
    bus_write(REG_CON, 32'h28);
    bus_write(REG_TXD, 32'h00);
    idle(170);
    chk_irq("irq_tx_done");
    bus_write(REG_CON, 32'h60);
    chk_irq("irq_tx_done_cleared");
    bus_read(REG_CON);

    // Combined strobes and the reserved address.
    bus_cycle(1'b1, 1'b1, REG_CON, 32'h10);
    bus_cycle(1'b1, 1'b1, REG_RXD, 32'hFF);
    bus_write(REG_RSV, 32'hFFFF_FFFF);
    bus_read(REG_RSV);
    bus_read(REG_CON);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: send_rx(8'($urandom), ($urandom_range(0, 7) != 0), 1'b0, 1'b0);
        1: bus_write(REG_TXD, $urandom);
        2: bus_read(REG_CON);
        3: bus_read(REG_RXD);
        4: bus_write(REG_CON, $urandom & 32'h7F);
        default: idle($urandom_range(1, 60));
      endcase
      chk_irq("irq_random");
    end

    idle(200);
    bus_read(REG_CON);
    idle(2);
    check("tx_queue_drained", 32'(exp_tx_q.size()), 32'h0);
    check("read_queue_drained", 32'(exp_rd_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
